mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 2: the number of consecutive data grants allowed while a fetch waits, range 1..7.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port if_req, input, 1: fetch read request; held with if_adr stable until granted.
REQ-005 SHALL have port if_adr, input, 32: fetch address.
REQ-006 SHALL have port if_flush, input, 1: redirect; kills any in-flight fetch response.
REQ-007 SHALL have port if_gnt, output, 1: fetch request accepted this cycle.
REQ-008 SHALL have port if_rvalid, output, 1: if_rdata is valid.
REQ-009 SHALL have port if_rdata, output, 32: fetch read data.
REQ-010 SHALL have ports d_req (input, 1), d_we (input, 1), d_adr (input, 32), d_wdata (input, 32) and d_wmask (input, 4): data-stage request, held stable until granted.
REQ-011 SHALL have ports d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, 32): data grant, completion, and read data.
REQ-012 SHALL have ports m_en (output, 1), m_we (output, 1), m_adr (output, 32), m_wdata (output, 32) and m_wmask (output, 4): single-port memory command.
REQ-013 SHALL have port m_rdata, input, 32: memory read data, valid one cycle after a read command.

Function
REQ-014 SHALL grant at most one requester per cycle; if_gnt and d_gnt are combinational from the requests and state, and are never both high.
REQ-015 SHALL drive m_en=1 only in a grant cycle, with m_adr/m_we/m_wdata/m_wmask taken from the granted requester; a fetch drives m_we=0 and m_wmask=0.
REQ-016 SHALL give the data port priority when both requests are high, except when the starve counter equals STARVE_LIMIT, in which case the fetch port wins.
REQ-017 SHALL increment the starve counter on each d_gnt cycle while if_req=1, clear it on if_gnt or whenever if_req=0, and saturate it at STARVE_LIMIT.
REQ-018 SHALL register a response tag each cycle with one of the values NONE, IF, DRD or DWR, according to that cycle's grant.
REQ-019 SHALL assert exactly one completion pulse the cycle after a grant, and SHALL accept back-to-back grants every cycle (throughput 1 per cycle).
REQ-020 SHALL, for tag IF, drive if_rvalid=1 and if_rdata=m_rdata.
REQ-021 SHALL, for tag DRD, drive d_rvalid=1 and d_rdata=m_rdata.
REQ-022 SHALL, for tag DWR, drive d_rvalid=1 and d_rdata=0 (write acknowledge).
REQ-023 SHALL drive if_rdata and d_rdata to 0 whenever their respective valid is low.
REQ-024 SHALL, when if_flush=1, block if_gnt in that cycle and convert a registered IF tag to NONE, so that no if_rvalid is produced in the following cycle.
REQ-025 SHALL leave data requests, the data tag and the starve counter unaffected by if_flush.
REQ-026 SHALL, when if_flush=1 coincides with tag IF present, still allow a data grant in that cycle.
REQ-027 SHALL produce no grant, no m_en and no completion when neither request is high.
REQ-028 SHALL NOT check address alignment or range; the memory command is passed through unchanged.

Reset
REQ-029 SHALL, while rst=0, force tag=NONE, starve counter=0, all gnt/rvalid/m_en/m_we outputs 0, and all data/address outputs 0.
REQ-030 SHALL discard an operation in flight when reset is asserted: no completion pulse is issued after rst is released.
REQ-031 SHALL allow a grant on the first rising edge after rst rises if a request is present.

Verification
REQ-032 Fetch only: if_req=1, if_adr=0x100, m_rdata=0xDEADBEEF next cycle -> if_gnt=1 in cycle 0; m_en=1, m_adr=0x100 in cycle 0; if_rvalid=1, if_rdata=0xDEADBEEF in cycle 1.
REQ-033 Contention: if_req=1 and d_req=1 held for 4 cycles, STARVE_LIMIT=2 -> grant order D, D, IF, D; starve counter reads 0, 1, 2, 0.
REQ-034 Data write: d_we=1, d_adr=0x2004, d_wdata=0x55AA, d_wmask=0b0011 -> m_we=1 with the same fields in the grant cycle; d_rvalid=1, d_rdata=0 in the next cycle.
REQ-035 Flush: fetch granted at 0x200, if_flush=1 in the next cycle -> if_rvalid stays 0 and if_gnt=0 in the flush cycle; a new fetch at 0x300 is granted the cycle after.
REQ-036 Reset mid-operation: data read granted, rst=0 applied before the next edge -> d_rvalid never pulses; all outputs are 0 until rst=1.
REQ-037 Back-to-back: alternate fetch-only and data-only requests for 6 cycles -> m_en=1 every cycle and exactly 6 completions in order with matching data.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch + data) sharing one single-port memory.
// Data wins by default; a fetch starved for STARVE_LIMIT data grants takes the next slot.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_adr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_adr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  input  logic [31:0] m_rdata
);

  typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_DRD, TAG_DWR} tag_e;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  tag_e       tag_q, tag_d;
  logic [2:0] starve_q, starve_d;

  // Grant selection and memory command; rst gating keeps every output low during reset.
  always_comb begin
    if_gnt  = rst && if_req && !if_flush && (!d_req || starve_q == LIMIT);
    d_gnt   = rst && d_req && !if_gnt;
    m_en    = if_gnt || d_gnt;
    m_we    = d_gnt && d_we;
    m_adr   = '0;
    m_wdata = '0;
    m_wmask = '0;
    if (if_gnt) begin
      m_adr = if_adr;
    end else if (d_gnt) begin
      m_adr   = d_adr;
      m_wdata = d_wdata;
      m_wmask = d_wmask;
    end
  end

  always_comb begin
    tag_d = TAG_NONE;
    if (if_gnt)
      tag_d = TAG_IF;
    else if (d_gnt)
      tag_d = d_we ? TAG_DWR : TAG_DRD;

    starve_d = starve_q;
    if (!if_req || if_gnt)
      starve_d = '0;
    else if (d_gnt && starve_q != LIMIT)
      starve_d = starve_q + 3'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q    <= TAG_NONE;
      starve_q <= '0;
    end else begin
      tag_q    <= tag_d;
      starve_q <= starve_d;
    end
  end

  // A flush in the response cycle squashes the fetch completion that was in flight.
  always_comb begin
    if_rvalid = rst && (tag_q == TAG_IF) && !if_flush;
    if_rdata  = if_rvalid ? m_rdata : '0;
    d_rvalid  = rst && (tag_q == TAG_DRD || tag_q == TAG_DWR);
    d_rdata   = (rst && tag_q == TAG_DRD) ? m_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge,
// outputs are checked 1ns later, well away from the rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush;
  logic [31:0] if_adr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_adr, d_wdata;
  logic [3:0]  d_wmask;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en, m_we;
  logic [31:0] m_adr, m_wdata;
  logic [3:0]  m_wmask;
  logic [31:0] m_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_adr(if_adr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle();
    if_req = 1'b0; if_flush = 1'b0; if_adr = '0;
    d_req = 1'b0; d_we = 1'b0; d_adr = '0; d_wdata = '0; d_wmask = '0;
  endtask

  task automatic all_quiet(input string tag);
    chk({tag, "_if_gnt"},    32'(if_gnt),    0);
    chk({tag, "_d_gnt"},     32'(d_gnt),     0);
    chk({tag, "_m_en"},      32'(m_en),      0);
    chk({tag, "_m_we"},      32'(m_we),      0);
    chk({tag, "_m_adr"},     m_adr,          0);
    chk({tag, "_m_wdata"},   m_wdata,        0);
    chk({tag, "_m_wmask"},   32'(m_wmask),   0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 0);
    chk({tag, "_if_rdata"},  if_rdata,       0);
    chk({tag, "_d_rvalid"},  32'(d_rvalid),  0);
    chk({tag, "_d_rdata"},   d_rdata,        0);
  endtask

  logic        exp_dg [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [2:0]  exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
  int          ncomp;

  initial begin
    rst = 1'b0;
    idle();
    m_rdata = 32'hCAFE_F00D;

    // Reset with both requests up: nothing may be granted or driven.
    @(negedge clk);
    if_req = 1'b1; if_adr = 32'h1234; d_req = 1'b1; d_adr = 32'h5678; d_wdata = 32'h9; d_wmask = 4'hF; d_we = 1'b1;
    #1 all_quiet("rst");
    chk("rst_starve", 32'(dut.starve_q), 0);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1 all_quiet("idle");

    // Fetch only.
    @(negedge clk);
    if_req = 1'b1; if_adr = 32'h100;
    #1;
    chk("f_if_gnt", 32'(if_gnt), 1);
    chk("f_d_gnt",  32'(d_gnt),  0);
    chk("f_m_en",   32'(m_en),   1);
    chk("f_m_adr",  m_adr,       32'h100);
    chk("f_m_we",   32'(m_we),   0);
    @(negedge clk);
    idle(); m_rdata = 32'hDEAD_BEEF;
    #1;
    chk("f_if_rvalid", 32'(if_rvalid), 1);
    chk("f_if_rdata",  if_rdata,       32'hDEAD_BEEF);
    chk("f_m_en_idle", 32'(m_en),      0);
    @(negedge clk);
    #1;
    chk("f_if_rvalid_off", 32'(if_rvalid), 0);
    chk("f_if_rdata_zero", if_rdata,       0);
    chk("f_d_rdata_zero",  d_rdata,        0);

    // Contention with STARVE_LIMIT=2: D, D, IF, D.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_rdata = 32'h1000 + 32'(i);
      if (i < 4) begin
        if_req = 1'b1; if_adr = 32'h80; d_req = 1'b1; d_we = 1'b0; d_adr = 32'h40;
      end else idle();
      #1;
      if (i < 4) begin
        chk($sformatf("c%0d_d_gnt", i),  32'(d_gnt),         32'(exp_dg[i]));
        chk($sformatf("c%0d_if_gnt", i), 32'(if_gnt),        32'(!exp_dg[i]));
        chk($sformatf("c%0d_starve", i), 32'(dut.starve_q),  32'(exp_st[i]));
        chk($sformatf("c%0d_m_adr", i),  m_adr,              exp_dg[i] ? 32'h40 : 32'h80);
      end
      if (i > 0) begin
        chk($sformatf("c%0d_d_rvalid", i),  32'(d_rvalid),  32'(exp_dg[i-1]));
        chk($sformatf("c%0d_if_rvalid", i), 32'(if_rvalid), 32'(!exp_dg[i-1]));
        chk($sformatf("c%0d_rdata", i), exp_dg[i-1] ? d_rdata : if_rdata, 32'h1000 + 32'(i));
      end
    end

    // Data write.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_adr = 32'h2004; d_wdata = 32'h55AA; d_wmask = 4'b0011;
    #1;
    chk("w_d_gnt",   32'(d_gnt),   1);
    chk("w_m_en",    32'(m_en),    1);
    chk("w_m_we",    32'(m_we),    1);
    chk("w_m_adr",   m_adr,        32'h2004);
    chk("w_m_wdata", m_wdata,      32'h55AA);
    chk("w_m_wmask", 32'(m_wmask), 32'h3);
    @(negedge clk);
    idle(); m_rdata = 32'hFFFF_FFFF;
    #1;
    chk("w_d_rvalid", 32'(d_rvalid), 1);
    chk("w_d_rdata",  d_rdata,       0);

    // Flush: fetch at 0x200, flush next cycle alongside a data read.
    @(negedge clk);
    idle(); if_req = 1'b1; if_adr = 32'h200;
    #1;
    chk("fl_gnt0", 32'(if_gnt), 1);
    chk("fl_adr0", m_adr,       32'h200);
    @(negedge clk);
    if_adr = 32'h300; if_flush = 1'b1; d_req = 1'b1; d_we = 1'b0; d_adr = 32'h44; m_rdata = 32'h7777_0000;
    #1;
    chk("fl_if_gnt",    32'(if_gnt),    0);
    chk("fl_if_rvalid", 32'(if_rvalid), 0);
    chk("fl_if_rdata",  if_rdata,       0);
    chk("fl_d_gnt",     32'(d_gnt),     1);
    chk("fl_m_adr",     m_adr,          32'h44);
    @(negedge clk);
    if_flush = 1'b0; d_req = 1'b0; d_adr = '0; m_rdata = 32'h4444_0000;
    #1;
    chk("fl_if_gnt2",  32'(if_gnt),    1);
    chk("fl_m_adr2",   m_adr,          32'h300);
    chk("fl_d_rvalid", 32'(d_rvalid),  1);
    chk("fl_d_rdata",  d_rdata,        32'h4444_0000);
    chk("fl_if_rv2",   32'(if_rvalid), 0);
    @(negedge clk);
    idle(); m_rdata = 32'h3030_3030;
    #1;
    chk("fl_if_rvalid3", 32'(if_rvalid), 1);
    chk("fl_if_rdata3",  if_rdata,       32'h3030_3030);

    // Reset while a data read is in flight.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_adr = 32'h88;
    #1 chk("r_d_gnt", 32'(d_gnt), 1);
    #2 rst = 1'b0;
    #1 all_quiet("r_assert");
    @(negedge clk);
    m_rdata = 32'hBAD0_BAD0;
    #1 all_quiet("r_held");
    @(negedge clk);
    idle(); rst = 1'b1;
    #1 all_quiet("r_release");
    @(negedge clk);
    if_req = 1'b1; if_adr = 32'h600;
    #1;
    chk("r_first_gnt", 32'(if_gnt), 1);
    chk("r_d_rvalid",  32'(d_rvalid), 0);
    @(negedge clk);
    idle();
    #1 chk("r_first_rv", 32'(if_rvalid), 1);
    @(negedge clk);

    // Back-to-back alternating fetch / data read.
    ncomp = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      m_rdata = 32'hA0 + 32'(i);
      idle();
      if (i < 6) begin
        if (i % 2 == 0) begin if_req = 1'b1; if_adr = 32'h400 + 32'(i * 4); end
        else begin d_req = 1'b1; d_adr = 32'h500 + 32'(i * 4); end
      end
      #1;
      ncomp += int'(if_rvalid) + int'(d_rvalid);
      if (i < 6) begin
        chk($sformatf("b%0d_m_en", i), 32'(m_en), 1);
        chk($sformatf("b%0d_m_adr", i), m_adr, (i % 2 == 0) ? 32'h400 + 32'(i * 4) : 32'h500 + 32'(i * 4));
      end
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          chk($sformatf("b%0d_if_rv", i), 32'(if_rvalid), 1);
          chk($sformatf("b%0d_if_rd", i), if_rdata, 32'hA0 + 32'(i));
        end else begin
          chk($sformatf("b%0d_d_rv", i), 32'(d_rvalid), 1);
          chk($sformatf("b%0d_d_rd", i), d_rdata, 32'hA0 + 32'(i));
        end
      end
    end
    chk("b_ncomp", 32'(ncomp), 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
